// File: rtl/fft_pkg.sv
// Shared definitions for the 32-point FFT datapath: widths, the complex word type
// and the lane/phase to frame-element mapping used by both the MAC stage and the collector.
package fft_pkg;

    localparam int CPLX_W = 64;
    localparam int N_PTS  = 32;
    localparam int LANES  = 8;
    localparam int PHASES = 4;
    localparam int LANE_W = 3;
    localparam int PH_W   = 2;
    localparam int IDX_W  = 5;

    typedef logic [CPLX_W-1:0] cplx_t;

    // Lanes 0-3 land on 4k+p and lanes 4-7 on 16+4(k-4)+p, which is just {lane, phase}.
    function automatic logic [IDX_W-1:0] lane_to_index(input logic [LANE_W-1:0] lane,
                                                       input logic [PH_W-1:0]   phase);
        return {lane[2], lane[1:0], phase};
    endfunction

endpackage

// File: rtl/fft_frame_bank.sv
// One 32-element frame buffer: an 8-lane write port steered by phase and a flat read port.
module fft_frame_bank
    import fft_pkg::*;
(
    input  logic                    clk,
    input  logic                    i_we,
    input  logic [PH_W-1:0]         i_phase,
    input  logic [LANES*CPLX_W-1:0] i_data,
    output logic [N_PTS*CPLX_W-1:0] o_frame
);

    cplx_t r_mem [N_PTS];

    // Scatter the eight lanes of a beat into their frame slots; contents carry no reset.
    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int k = 0; k < LANES; k++) begin
                r_mem[lane_to_index(LANE_W'(k), i_phase)] <= i_data[k*CPLX_W +: CPLX_W];
            end
        end
    end

    for (genvar i = 0; i < N_PTS; i++) begin : g_rd
        assign o_frame[i*CPLX_W +: CPLX_W] = r_mem[i];
    end

endmodule

// File: rtl/fft_stage_collector.sv
// Gathers four MAC phases into 32-element frames held in ping-pong banks and hands
// completed frames downstream over valid/ready; flags out-of-order and overflow beats.
module fft_stage_collector
    import fft_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    input  logic [PH_W-1:0]         in_phase,
    input  logic [LANES*CPLX_W-1:0] in_data,
    output logic                    in_ready,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [N_PTS*CPLX_W-1:0] outmac,
    output logic                    err_phase,
    output logic                    err_ovf,
    input  logic                    clr_err
);

    logic [PH_W-1:0] r_exp_ph;
    logic            r_wr_bank;
    logic            r_rd_bank;
    logic [1:0]      r_full;
    logic            r_err_phase;
    logic            r_err_ovf;

    logic                    w_accept;
    logic                    w_drain;
    logic                    w_write;
    logic                    w_complete;
    logic                    w_set_phase;
    logic                    w_set_ovf;
    logic [PH_W-1:0]         w_nxt_exp;
    logic [1:0]              w_nxt_full;
    logic [1:0]              w_bank_we;
    logic [N_PTS*CPLX_W-1:0] w_frame0;
    logic [N_PTS*CPLX_W-1:0] w_frame1;

    assign in_ready  = ~r_full[r_wr_bank];
    assign out_valid = r_full[r_rd_bank];
    assign outmac    = r_rd_bank ? w_frame1 : w_frame0;
    assign err_phase = r_err_phase;
    assign err_ovf   = r_err_ovf;
    assign w_accept  = in_valid & in_ready;
    assign w_drain   = out_valid & out_ready;
    assign w_bank_we = {w_write & r_wr_bank, w_write & ~r_wr_bank};

    // Phase checker: decides whether a beat is written, completes a frame, or restarts the sequence.
    always_comb begin
        w_nxt_exp   = r_exp_ph;
        w_write     = 1'b0;
        w_complete  = 1'b0;
        w_set_phase = 1'b0;
        w_set_ovf   = 1'b0;
        if (w_accept) begin
            if (in_phase == r_exp_ph) begin
                w_write = 1'b1;
                if (in_phase == 2'd3) begin
                    w_complete = 1'b1;
                    w_nxt_exp  = 2'd0;
                end else begin
                    w_nxt_exp  = r_exp_ph + 2'd1;
                end
            end else begin
                w_set_phase = 1'b1;
                // A stray phase 0 is taken as the start of a fresh frame rather than dropped.
                if (in_phase == 2'd0) begin
                    w_write   = 1'b1;
                    w_nxt_exp = 2'd1;
                end else begin
                    w_nxt_exp = 2'd0;
                end
            end
        end else if (in_valid) begin
            w_set_ovf = 1'b1;
            w_nxt_exp = 2'd0;
        end else begin
            w_nxt_exp = r_exp_ph;
        end
    end

    // Full-flag update; completion and drain always target different banks, so both may apply.
    always_comb begin
        w_nxt_full = r_full;
        if (w_complete) begin
            w_nxt_full[r_wr_bank] = 1'b1;
        end else begin
            w_nxt_full[r_wr_bank] = r_full[r_wr_bank];
        end
        if (w_drain) begin
            w_nxt_full[r_rd_bank] = 1'b0;
        end else begin
            w_nxt_full[r_rd_bank] = w_nxt_full[r_rd_bank];
        end
    end

    // Control state: phase counter, bank pointers, full flags and sticky error flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_exp_ph    <= 2'd0;
            r_wr_bank   <= 1'b0;
            r_rd_bank   <= 1'b0;
            r_full      <= 2'b00;
            r_err_phase <= 1'b0;
            r_err_ovf   <= 1'b0;
        end else begin
            r_exp_ph    <= w_nxt_exp;
            r_full      <= w_nxt_full;
            r_wr_bank   <= r_wr_bank ^ w_complete;
            r_rd_bank   <= r_rd_bank ^ w_drain;
            r_err_phase <= clr_err ? 1'b0 : (r_err_phase | w_set_phase);
            r_err_ovf   <= clr_err ? 1'b0 : (r_err_ovf | w_set_ovf);
        end
    end

    fft_frame_bank u_bank0 (
        .clk     (clk),
        .i_we    (w_bank_we[0]),
        .i_phase (in_phase),
        .i_data  (in_data),
        .o_frame (w_frame0)
    );

    fft_frame_bank u_bank1 (
        .clk     (clk),
        .i_we    (w_bank_we[1]),
        .i_phase (in_phase),
        .i_data  (in_data),
        .o_frame (w_frame1)
    );

endmodule

// File: tb/tb_fft_stage_collector.sv
// Directed-vector bench for fft_stage_collector: each frame element is {tag, index}.
module tb_fft_stage_collector;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic [1:0]    in_phase;
    logic [511:0]  in_data;
    logic          in_ready;
    logic          out_valid;
    logic          out_ready;
    logic [2047:0] outmac;
    logic          err_phase;
    logic          err_ovf;
    logic          clr_err;

    int n_vec = 0;
    int n_err = 0;

    fft_stage_collector dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_phase  (in_phase),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .outmac    (outmac),
        .err_phase (err_phase),
        .err_ovf   (err_ovf),
        .clr_err   (clr_err)
    );

    always #5 clk = ~clk;

    function automatic logic [511:0] mk_beat(input int tag, input int p);
        logic [511:0] d;
        int idx;
        d = '0;
        for (int k = 0; k < 8; k++) begin
            idx = (k < 4) ? (4*k + p) : (16 + 4*(k-4) + p);
            d[k*64 +: 64] = {32'(tag), 32'(idx)};
        end
        return d;
    endfunction

    function automatic logic [2047:0] mk_frame(input int tag);
        logic [2047:0] f;
        for (int i = 0; i < 32; i++) f[i*64 +: 64] = {32'(tag), 32'(i)};
        return f;
    endfunction

    task automatic send_beat(input int tag, input int p);
        in_valid = 1'b1;
        in_phase = 2'(p);
        in_data  = mk_beat(tag, p);
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic consume();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; in_valid = 1'b0; in_phase = 2'd0; in_data = '0;
        out_ready = 1'b0; clr_err = 1'b0;
        repeat (2) @(posedge clk);
        #1; reset = 1'b1;
        idle(1);
        n_vec++;
        if ({out_valid, in_ready, err_phase, err_ovf} !== 4'b0100) begin
            n_err++;
            $display("FAIL reset_state: got v/r/ep/eo=%b want 0100", {out_valid, in_ready, err_phase, err_ovf});
        end
    endtask

    task automatic test_single_frame();
        for (int p = 0; p < 3; p++) send_beat(0, p);
        n_vec++;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL single_early_valid: got %b want 0", out_valid); end
        send_beat(0, 3);
        in_valid = 1'b0;
        n_vec++;
        if (out_valid !== 1'b1) begin n_err++; $display("FAIL single_valid: got %b want 1", out_valid); end
        n_vec++;
        if (outmac !== mk_frame(0)) begin
            n_err++;
            $display("FAIL single_data: elem0 got %h want %h, elem31 got %h want %h",
                     outmac[63:0], 64'h0, outmac[2047:1984], 64'h1f);
        end
        consume();
        n_vec++;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL single_drain: got %b want 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        for (int f = 0; f < 3; f++) begin
            for (int p = 0; p < 4; p++) begin
                send_beat(1 + f, p);
                n_vec++;
                if (out_valid !== (p == 3)) begin
                    n_err++;
                    $display("FAIL b2b_valid f%0d p%0d: got %b want %b", f, p, out_valid, (p == 3));
                end
                if (p == 3) begin
                    n_vec++;
                    if (outmac !== mk_frame(1 + f)) begin
                        n_err++;
                        $display("FAIL b2b_data f%0d: elem5 got %h want %h", f, outmac[383:320], {32'(1 + f), 32'd5});
                    end
                    n_vec++;
                    if (in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready f%0d: got %b want 1", f, in_ready); end
                end
            end
        end
        idle(1);
        out_ready = 1'b0;
        n_vec++;
        if ({out_valid, err_phase, err_ovf} !== 3'b000) begin
            n_err++;
            $display("FAIL b2b_end: got v/ep/eo=%b want 000", {out_valid, err_phase, err_ovf});
        end
    endtask

    task automatic test_stall();
        out_ready = 1'b0;
        for (int p = 0; p < 4; p++) send_beat(10, p);
        n_vec++;
        if (out_valid !== 1'b1) begin n_err++; $display("FAIL stall_first_valid: got %b want 1", out_valid); end
        for (int p = 0; p < 4; p++) send_beat(11, p);
        n_vec++;
        if (in_ready !== 1'b0) begin n_err++; $display("FAIL stall_ready: got %b want 0", in_ready); end
        clr_err = 1'b1;
        send_beat(12, 0);
        clr_err = 1'b0;
        n_vec++;
        if (err_ovf !== 1'b0) begin n_err++; $display("FAIL stall_clr_priority: got %b want 0", err_ovf); end
        send_beat(12, 0);
        n_vec++;
        if (err_ovf !== 1'b1) begin n_err++; $display("FAIL stall_ovf: got %b want 1", err_ovf); end
        n_vec++;
        if (outmac !== mk_frame(10)) begin
            n_err++;
            $display("FAIL stall_hold: elem0 got %h want %h", outmac[63:0], {32'd10, 32'd0});
        end
        consume();
        n_vec++;
        if ({out_valid, in_ready} !== 2'b11) begin
            n_err++;
            $display("FAIL stall_second_valid: got v/r=%b want 11", {out_valid, in_ready});
        end
        n_vec++;
        if (outmac !== mk_frame(11)) begin
            n_err++;
            $display("FAIL stall_second_data: elem0 got %h want %h", outmac[63:0], {32'd11, 32'd0});
        end
        consume();
        clr_err = 1'b1;
        idle(1);
        clr_err = 1'b0;
        n_vec++;
        if ({out_valid, err_ovf} !== 2'b00) begin
            n_err++;
            $display("FAIL stall_clear: got v/eo=%b want 00", {out_valid, err_ovf});
        end
    endtask

    task automatic test_phase_skip();
        send_beat(20, 0);
        send_beat(20, 1);
        send_beat(20, 3);
        in_valid = 1'b0;
        n_vec++;
        if ({err_phase, out_valid} !== 2'b10) begin
            n_err++;
            $display("FAIL skip_err: got ep/v=%b want 10", {err_phase, out_valid});
        end
        for (int p = 0; p < 3; p++) send_beat(21, p);
        n_vec++;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL skip_early_valid: got %b want 0", out_valid); end
        send_beat(21, 3);
        n_vec++;
        if (out_valid !== 1'b1) begin n_err++; $display("FAIL skip_valid: got %b want 1", out_valid); end
        n_vec++;
        if (outmac !== mk_frame(21)) begin
            n_err++;
            $display("FAIL skip_data: elem1 got %h want %h", outmac[127:64], {32'd21, 32'd1});
        end
        consume();
        clr_err = 1'b1;
        idle(1);
        clr_err = 1'b0;
        n_vec++;
        if (err_phase !== 1'b0) begin n_err++; $display("FAIL skip_clr: got %b want 0", err_phase); end
    endtask

    task automatic test_phase_restart();
        send_beat(30, 0);
        send_beat(30, 1);
        send_beat(31, 0);
        n_vec++;
        if (err_phase !== 1'b1) begin n_err++; $display("FAIL restart_err: got %b want 1", err_phase); end
        for (int p = 1; p < 4; p++) send_beat(31, p);
        in_valid = 1'b0;
        n_vec++;
        if (out_valid !== 1'b1) begin n_err++; $display("FAIL restart_valid: got %b want 1", out_valid); end
        n_vec++;
        if (outmac !== mk_frame(31)) begin
            n_err++;
            $display("FAIL restart_data: elem0 got %h want %h, elem1 got %h want %h",
                     outmac[63:0], {32'd31, 32'd0}, outmac[127:64], {32'd31, 32'd1});
        end
        consume();
    endtask

    task automatic test_reset_mid();
        for (int p = 0; p < 4; p++) send_beat(39, p);
        for (int p = 0; p < 3; p++) send_beat(40, p);
        in_valid = 1'b0;
        n_vec++;
        if ({out_valid, err_phase} !== 2'b11) begin
            n_err++;
            $display("FAIL rstmid_pre: got v/ep=%b want 11", {out_valid, err_phase});
        end
        reset = 1'b0;
        #2;
        n_vec++;
        if ({out_valid, in_ready, err_phase, err_ovf} !== 4'b0100) begin
            n_err++;
            $display("FAIL rstmid_async: got v/r/ep/eo=%b want 0100", {out_valid, in_ready, err_phase, err_ovf});
        end
        @(posedge clk); #1;
        reset = 1'b1;
        idle(1);
        send_beat(40, 3);
        in_valid = 1'b0;
        n_vec++;
        if ({out_valid, err_phase} !== 2'b01) begin
            n_err++;
            $display("FAIL rstmid_partial: got v/ep=%b want 01", {out_valid, err_phase});
        end
        for (int p = 0; p < 4; p++) send_beat(41, p);
        in_valid = 1'b0;
        n_vec++;
        if (out_valid !== 1'b1) begin n_err++; $display("FAIL rstmid_valid: got %b want 1", out_valid); end
        n_vec++;
        if (outmac !== mk_frame(41)) begin
            n_err++;
            $display("FAIL rstmid_data: elem31 got %h want %h", outmac[2047:1984], {32'd41, 32'd31});
        end
        consume();
        n_vec++;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_drain: got %b want 0", out_valid); end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_stall();
        test_phase_skip();
        test_phase_restart();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
